// File: rtl/snoop_dispatch_pkg.sv
// Shared definitions for the snoop dispatcher: FSM state encoding and a
// constant-function log2 used to size tag index slices.
package snoop_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/snoop_dispatch_onehot_dec.sv
// Tag to one-hot buffer select; tags at or beyond N decode to all-zero so a
// bogus grant can never strobe a buffer.
module tag_onehot_dec
    import snoop_dispatch_pkg::*;
#(
    parameter int N      = 4,
    parameter int TAG_SZ = 5
) (
    input  logic [TAG_SZ-1:0] i_tag,
    output logic [N-1:0]      o_onehot
);

    localparam int IDX_W = (N > 1) ? clog2(N) : 1;

    always_comb begin
        o_onehot = '0;
        if (i_tag < TAG_SZ'(N)) begin
            o_onehot[i_tag[IDX_W-1:0]] = 1'b1;
        end
    end

endmodule

// File: rtl/snoop_dispatch.sv
// Holds one packet-buffer grant from tag_tree and steers the snooper write
// stream to that buffer through a single register stage; ungranted packets are dropped.
module snoop_dispatch
    import snoop_dispatch_pkg::*;
#(
    parameter int N          = 4,
    parameter int TAG_SZ     = 5,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [TAG_SZ-1:0]     i_tag,
    input  logic                  i_tag_rdy,
    output logic                  o_tag_ack,
    input  logic [ADDR_WIDTH-1:0] i_sn_addr,
    input  logic [DATA_WIDTH-1:0] i_sn_wr_data,
    input  logic                  i_sn_wr_en,
    input  logic                  i_sn_done,
    output logic                  o_sn_rdy,
    output logic [ADDR_WIDTH-1:0] o_core_addr,
    output logic [DATA_WIDTH-1:0] o_core_wr_data,
    output logic [N-1:0]          o_core_wr_en,
    output logic [N-1:0]          o_core_done,
    output logic [DROP_CNT_W-1:0] o_drop_cnt,
    output state_t                o_dbg_state
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TAG_SZ-1:0]     r_held_tag;
    logic [ADDR_WIDTH-1:0] r_core_addr;
    logic [DATA_WIDTH-1:0] r_core_wr_data;
    logic [N-1:0]          r_core_wr_en;
    logic [N-1:0]          r_core_done;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic [N-1:0]          w_held_oh;
    logic                  w_tag_ack;
    logic                  w_drop_inc;

    tag_onehot_dec #(
        .N      (N),
        .TAG_SZ (TAG_SZ)
    ) u_held_dec (
        .i_tag    (r_held_tag),
        .o_onehot (w_held_oh)
    );

    // Tag handshake: tag_tree presents i_tag with i_tag_rdy; a grant transfers on
    // the edge where o_tag_ack is high. Acks are withheld while a packet is
    // beating in so a packet never starts mid-stream on a fresh grant.
    assign w_tag_ack = i_tag_rdy & (r_state == ST_IDLE) & ~i_sn_wr_en;

    always_comb begin
        w_state_nxt = r_state;
        w_drop_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_sn_wr_en) begin
                    if (i_sn_done) begin
                        w_drop_inc = 1'b1;
                    end else begin
                        w_state_nxt = ST_DROP;
                    end
                end else if (w_tag_ack) begin
                    w_state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (i_sn_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (i_sn_done) begin
                    w_drop_inc  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_held_tag     <= '0;
            r_core_addr    <= '0;
            r_core_wr_data <= '0;
            r_core_wr_en   <= '0;
            r_core_done    <= '0;
            r_drop_cnt     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_core_wr_en <= '0;
            r_core_done  <= '0;
            if (w_tag_ack) begin
                r_held_tag <= i_tag;
            end
            // Address/data hold between beats so buffers see stable values.
            if (r_state == ST_HELD) begin
                if (i_sn_wr_en) begin
                    r_core_wr_en   <= w_held_oh;
                    r_core_addr    <= i_sn_addr;
                    r_core_wr_data <= i_sn_wr_data;
                end
                if (i_sn_done) begin
                    r_core_done <= w_held_oh;
                end
            end
            if (w_drop_inc && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign o_tag_ack      = w_tag_ack;
    assign o_sn_rdy       = (r_state == ST_HELD);
    assign o_core_addr    = r_core_addr;
    assign o_core_wr_data = r_core_wr_data;
    assign o_core_wr_en   = r_core_wr_en;
    assign o_core_done    = r_core_done;
    assign o_drop_cnt     = r_drop_cnt;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_snoop_dispatch.sv
// Scoreboard bench for snoop_dispatch: directed scenarios followed by random
// traffic, predicted by a grant/packet-level reference model.
module tb_snoop_dispatch;
  import snoop_dispatch_pkg::*;

  localparam int N      = 4;
  localparam int TAG_SZ = 5;
  localparam int AW     = 10;
  localparam int DW     = 64;
  localparam int DCW    = 2;
  localparam int EXP_W  = 32 + N + N + AW + DW;

  // clock / reset
  logic clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 clk = ~clk;

  logic [TAG_SZ-1:0] i_tag = '0;
  logic              i_tag_rdy = 1'b0;
  logic [AW-1:0]     i_sn_addr = '0;
  logic [DW-1:0]     i_sn_wr_data = '0;
  logic              i_sn_wr_en = 1'b0;
  logic              i_sn_done = 1'b0;
  logic              o_tag_ack;
  logic              o_sn_rdy;
  logic [AW-1:0]     o_core_addr;
  logic [DW-1:0]     o_core_wr_data;
  logic [N-1:0]      o_core_wr_en;
  logic [N-1:0]      o_core_done;
  logic [DCW-1:0]    o_drop_cnt;
  state_t            o_dbg_state;

  snoop_dispatch #(
    .N(N), .TAG_SZ(TAG_SZ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DROP_CNT_W(DCW)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_tag(i_tag), .i_tag_rdy(i_tag_rdy),
    .o_tag_ack(o_tag_ack), .i_sn_addr(i_sn_addr), .i_sn_wr_data(i_sn_wr_data),
    .i_sn_wr_en(i_sn_wr_en), .i_sn_done(i_sn_done), .o_sn_rdy(o_sn_rdy),
    .o_core_addr(o_core_addr), .o_core_wr_data(o_core_wr_data),
    .o_core_wr_en(o_core_wr_en), .o_core_done(o_core_done),
    .o_drop_cnt(o_drop_cnt), .o_dbg_state(o_dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [EXP_W-1:0] exp_q[$];

  // reference model: current grant (-1 = none), packet-discard flag, drop count
  int          m_grant = -1;
  bit          m_discard = 1'b0;
  int          m_drops = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0 && g < N) r[g] = 1'b1;
    return r;
  endfunction

  function automatic state_t m_state();
    if (m_grant >= 0) return ST_HELD;
    if (m_discard) return ST_DROP;
    return ST_IDLE;
  endfunction

  task automatic model_reset();
    m_grant = -1;
    m_discard = 1'b0;
    m_drops = 0;
    m_addr = '0;
    m_data = '0;
  endtask

  // advance the model across one clock edge with the currently driven inputs
  task automatic model_step(input bit exp_ack);
    logic [N-1:0] we;
    logic [N-1:0] dn;
    logic [31:0]  when;
    we = '0;
    dn = '0;
    if (m_grant >= 0) begin
      if (i_sn_wr_en) begin
        we = oh(m_grant);
        m_addr = i_sn_addr;
        m_data = i_sn_wr_data;
      end
      if (i_sn_done) begin
        dn = oh(m_grant);
        m_grant = -1;
      end
    end else if (m_discard) begin
      if (i_sn_done) begin
        m_discard = 1'b0;
        if (m_drops < (1 << DCW) - 1) m_drops++;
      end
    end else if (i_sn_wr_en) begin
      if (i_sn_done) begin
        if (m_drops < (1 << DCW) - 1) m_drops++;
      end else begin
        m_discard = 1'b1;
      end
    end else if (exp_ack) begin
      m_grant = int'(i_tag);
    end
    if (we != '0 || dn != '0) begin
      when = 32'(cyc + 1);
      exp_q.push_back({when, we, dn, m_addr, m_data});
    end
  endtask

  // driver: apply one cycle of inputs, check combinational/status outputs mid-cycle
  task automatic drive_cycle(input bit rdy, input int tag, input bit wr, input bit done,
                             input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit exp_ack;
    i_tag_rdy = rdy;
    i_tag = TAG_SZ'(tag);
    i_sn_wr_en = wr;
    i_sn_done = done;
    i_sn_addr = addr;
    i_sn_wr_data = data;
    @(negedge clk);
    exp_ack = rdy && (m_grant < 0) && !m_discard && !wr;
    chk("tag_ack", 64'(o_tag_ack), 64'(exp_ack));
    chk("sn_rdy", 64'(o_sn_rdy), 64'(m_grant >= 0));
    chk("drop_cnt", 64'(o_drop_cnt), 64'(m_drops));
    chk("state", 64'(o_dbg_state), 64'(m_state()));
    model_step(exp_ack);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_tag_rdy = 1'b0;
    i_sn_wr_en = 1'b0;
    i_sn_done = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_wr_en", 64'(o_core_wr_en), 64'(0));
    chk("rst_done", 64'(o_core_done), 64'(0));
    chk("rst_addr", 64'(o_core_addr), 64'(0));
    chk("rst_data", o_core_wr_data, 64'(0));
    chk("rst_drop_cnt", 64'(o_drop_cnt), 64'(0));
    chk("rst_sn_rdy", 64'(o_sn_rdy), 64'(0));
    chk("rst_state", 64'(o_dbg_state), 64'(ST_IDLE));
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    model_reset();
  endtask

  // monitor: every visible core strobe must match the head of the expected queue
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (o_core_wr_en != '0 || o_core_done != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_core_out", {56'(o_core_wr_en), 4'(0), 4'(o_core_done)}, 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("core_cycle", 64'(cyc), 64'(e[EXP_W-1 -: 32]));
        chk("core_wr_en", 64'(o_core_wr_en), 64'(e[DW+AW+2*N-1 -: N]));
        chk("core_done", 64'(o_core_done), 64'(e[DW+AW+N-1 -: N]));
        chk("core_addr", 64'(o_core_addr), 64'(e[DW+AW-1 -: AW]));
        chk("core_data", o_core_wr_data, e[DW-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // acquire tag 2, ack only once
    drive_cycle(1'b1, 2, 1'b0, 1'b0, '0, '0);
    drive_cycle(1'b1, 2, 1'b0, 1'b0, '0, '0);
    chk("t1_sn_rdy", 64'(o_sn_rdy), 64'(1));

    // three-beat packet, done on last beat
    for (int a = 0; a < 3; a++)
      drive_cycle(1'b0, 0, 1'b1, a == 2, AW'(a), {$urandom, $urandom});
    idle_cycle();
    chk("t2_released", 64'(o_sn_rdy), 64'(0));

    // ungranted 5-beat packet, tag_rdy raised mid-packet
    for (int b = 0; b < 5; b++)
      drive_cycle(b >= 2, 3, 1'b1, b == 4, AW'(b + 16), {$urandom, $urandom});
    drive_cycle(1'b1, 3, 1'b0, 1'b0, '0, '0);
    chk("t3_drop_cnt", 64'(o_drop_cnt), 64'(1));
    drive_cycle(1'b0, 0, 1'b1, 1'b1, AW'(99), {$urandom, $urandom});

    // tag_rdy coincident with first beat: no ack, packet dropped
    drive_cycle(1'b1, 1, 1'b1, 1'b0, AW'(5), {$urandom, $urandom});
    drive_cycle(1'b1, 1, 1'b1, 1'b1, AW'(6), {$urandom, $urandom});
    idle_cycle();
    chk("t4_drop_cnt", 64'(o_drop_cnt), 64'(2));

    // out-of-range grant suppresses strobes
    drive_cycle(1'b1, 9, 1'b0, 1'b0, '0, '0);
    drive_cycle(1'b0, 0, 1'b1, 1'b0, AW'(7), {$urandom, $urandom});
    drive_cycle(1'b0, 0, 1'b1, 1'b1, AW'(8), {$urandom, $urandom});
    idle_cycle();

    // saturation
    do_reset();
    for (int k = 0; k < 4; k++)
      drive_cycle(1'b0, 0, 1'b1, 1'b1, AW'(k), {$urandom, $urandom});
    idle_cycle();
    chk("t5_drop_sat", 64'(o_drop_cnt), 64'(3));

    // reset mid-packet
    do_reset();
    drive_cycle(1'b1, 1, 1'b0, 1'b0, '0, '0);
    drive_cycle(1'b0, 0, 1'b1, 1'b0, AW'(40), {$urandom, $urandom});
    drive_cycle(1'b0, 0, 1'b1, 1'b0, AW'(41), {$urandom, $urandom});
    do_reset();
    idle_cycle();

    // random traffic
    for (int r = 0; r < 600; r++) begin
      int t;
      t = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 31)) : int'($urandom_range(0, 3));
      drive_cycle(1'($urandom_range(0, 1)), t, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 4) == 0, AW'($urandom), {$urandom, $urandom});
    end
    repeat (3) idle_cycle();
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
